// File: rtl/dm_arb_pkg.sv
// ---------------------------------------------------------------------------
// dm_arb_pkg
// Shared types and constants for the DM two-port arbiter.
//   state_e  : arbiter FSM states (IDLE -> ACCESS -> RESP)
//   PORT_A/B : requester ids, also used as the round-robin pointer encoding
//   NUM_REQ  : number of requesters served by the arbiter
//   req_t    : request latched in IDLE and replayed onto DM during ACCESS
// The address and data fields of req_t are REQ_AW / REQ_DW bits wide. The
// arbiter's AW / DW parameters must not exceed these widths.
// ---------------------------------------------------------------------------
package dm_arb_pkg;

  localparam int NUM_REQ = 2;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  localparam int REQ_AW = 32;
  localparam int REQ_DW = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  typedef struct packed {
    logic              we;
    logic [REQ_AW-1:0] addr;
    logic [REQ_DW-1:0] wdata;
    logic              owner;
  } req_t;

endpackage

// File: rtl/dm_arb_rr.sv
// ---------------------------------------------------------------------------
// dm_arb_rr
// Two-way round-robin winner selection and the rr_ptr register.
// When DM_ARB_LOCK_EN is defined, this module also holds the lock.
// Ports:
//   clk, reset      : clock, asynchronous active-high reset
//   a_req, b_req    : live request lines from the two ports
//   idle_en         : arbiter is in IDLE, so a winner may be chosen now
//   resp_en         : arbiter is in RESP for the access owned by resp_owner
//   resp_owner      : owner id of the access that is completing
//   a_lock, b_lock  : (DM_ARB_LOCK_EN only) per-port lock requests
//   win_valid       : a request should be latched this cycle
//   win_id          : id of the winning port
// ---------------------------------------------------------------------------
module dm_arb_rr
  import dm_arb_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic a_req,
  input  logic b_req,
  input  logic idle_en,
  input  logic resp_en,
  input  logic resp_owner,
`ifdef DM_ARB_LOCK_EN
  input  logic a_lock,
  input  logic b_lock,
`endif
  output logic win_valid,
  output logic win_id
);

  logic rr_ptr_q, rr_ptr_d;
  logic ptr_eff;
  logic owner_req;
  logic lock_held;
  logic lock_release;
  logic resp_lock;

`ifdef DM_ARB_LOCK_EN
  logic lock_q, lock_d;
  logic owner_lock;

  // While a lock is held, rr_ptr still points at the lock owner, so the
  // pointer doubles as the lock-owner id.
  assign owner_lock   = (rr_ptr_q == PORT_B) ? b_lock : a_lock;
  assign lock_held    = lock_q && owner_lock;
  assign lock_release = lock_q && !owner_lock;
  assign resp_lock    = (resp_owner == PORT_B) ? b_lock : a_lock;

  // The lock is taken in the owner's RESP cycle and dropped in IDLE once the
  // owner lets go of its lock line.
  always_comb begin
    lock_d = lock_q;
    if (resp_en) begin
      lock_d = resp_lock;
    end else if (idle_en && lock_release) begin
      lock_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock_q <= 1'b0;
    end else begin
      lock_q <= lock_d;
    end
  end
`else
  assign lock_held    = 1'b0;
  assign lock_release = 1'b0;
  assign resp_lock    = 1'b0;
`endif

  assign owner_req = (rr_ptr_q == PORT_B) ? b_req : a_req;

  // A released lock counts as the owner's turn, so the other port gets
  // priority in the same IDLE cycle in which the lock drops.
  assign ptr_eff = lock_release ? ~rr_ptr_q : rr_ptr_q;

  // Winner selection happens only in IDLE. A held lock masks the other port.
  always_comb begin
    win_valid = 1'b0;
    win_id    = ptr_eff;
    if (idle_en) begin
      if (lock_held) begin
        win_valid = owner_req;
        win_id    = rr_ptr_q;
      end else if (a_req && b_req) begin
        win_valid = 1'b1;
        win_id    = ptr_eff;
      end else if (a_req) begin
        win_valid = 1'b1;
        win_id    = PORT_A;
      end else if (b_req) begin
        win_valid = 1'b1;
        win_id    = PORT_B;
      end
    end
  end

  // The pointer moves to the other port when an access completes, unless the
  // completing owner asks to keep the lock.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (resp_en) begin
      rr_ptr_d = resp_lock ? resp_owner : ~resp_owner;
    end else if (idle_en && lock_release) begin
      rr_ptr_d = ~rr_ptr_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_q <= PORT_A;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

// File: rtl/dm_arbiter.sv
// ---------------------------------------------------------------------------
// dm_arbiter
// Two-requester round-robin sequencer in front of the DM data memory. It
// serializes port A (CPU load/store) and port B (loader/debug) onto DM's single
// port. Each completed access returns registered read data and a one-cycle
// grant pulse. The FSM runs IDLE -> ACCESS -> RESP, with one DM access per
// transaction.
// Optional feature: define DM_ARB_LOCK_EN to add the a_lock/b_lock inputs. A
// lock keeps the arbiter on one port for atomic read-modify-write sequences.
// Ports:
//   clk, reset               : clock, asynchronous active-high reset
//   a_req/a_we/a_addr/a_wdata: port A request, held until a_gnt
//   a_gnt, a_rdata           : port A completion pulse and held read data
//   b_*                      : same set for port B
//   a_lock, b_lock           : (DM_ARB_LOCK_EN only) lock requests
//   dm_addr/dm_writedata/dm_we: to DM
//   dm_readdata              : from DM (combinational read)
//   busy                     : high in ACCESS and RESP
// ---------------------------------------------------------------------------
module dm_arbiter
  import dm_arb_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_gnt,
  output logic [DW-1:0] a_rdata,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_gnt,
  output logic [DW-1:0] b_rdata,
`ifdef DM_ARB_LOCK_EN
  input  logic          a_lock,
  input  logic          b_lock,
`endif
  output logic [AW-1:0] dm_addr,
  output logic [DW-1:0] dm_writedata,
  output logic          dm_we,
  input  logic [DW-1:0] dm_readdata,
  output logic          busy
);

  state_e        state_q, state_d;
  req_t          req_q, req_d;
  logic [DW-1:0] a_rdata_q, a_rdata_d;
  logic [DW-1:0] b_rdata_q, b_rdata_d;
  logic          win_valid;
  logic          win_id;
  logic          idle_en;
  logic          resp_en;

  assign idle_en = (state_q == IDLE);
  assign resp_en = (state_q == RESP);

  dm_arb_rr u_rr (
    .clk        (clk),
    .reset      (reset),
    .a_req      (a_req),
    .b_req      (b_req),
    .idle_en    (idle_en),
    .resp_en    (resp_en),
    .resp_owner (req_q.owner),
`ifdef DM_ARB_LOCK_EN
    .a_lock     (a_lock),
    .b_lock     (b_lock),
`endif
    .win_valid  (win_valid),
    .win_id     (win_id)
  );

  // Requests are sampled only in IDLE. After a request is latched, the access
  // runs to completion even if the requester drops req. The read data is
  // captured at the end of ACCESS into the owner's register only.
  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;
    case (state_q)
      IDLE: begin
        if (win_valid) begin
          state_d = ACCESS;
          if (win_id == PORT_B) begin
            req_d.we    = b_we;
            req_d.addr  = REQ_AW'(b_addr);
            req_d.wdata = REQ_DW'(b_wdata);
            req_d.owner = PORT_B;
          end else begin
            req_d.we    = a_we;
            req_d.addr  = REQ_AW'(a_addr);
            req_d.wdata = REQ_DW'(a_wdata);
            req_d.owner = PORT_A;
          end
        end
      end
      ACCESS: begin
        state_d = RESP;
        if (req_q.owner == PORT_B) begin
          b_rdata_d = dm_readdata;
        end else begin
          a_rdata_d = dm_readdata;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      req_q     <= '0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
    end
  end

  // dm_addr and dm_writedata come straight from the latched request, so they
  // hold their last value outside ACCESS. dm_we is decoded from the state
  // register, which makes it fall as soon as reset is asserted.
  assign dm_addr      = AW'(req_q.addr);
  assign dm_writedata = DW'(req_q.wdata);
  assign dm_we        = (state_q == ACCESS) && req_q.we;

  assign a_gnt   = resp_en && (req_q.owner == PORT_A);
  assign b_gnt   = resp_en && (req_q.owner == PORT_B);
  assign a_rdata = a_rdata_q;
  assign b_rdata = b_rdata_q;
  assign busy    = (state_q == ACCESS) || (state_q == RESP);

endmodule

// File: tb/tb_dm_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dm_arbiter
// Directed bench for dm_arbiter. A small write-first DM model sits behind the
// arbiter. Inputs are driven and outputs are sampled 1 ns after each rising
// edge. A negedge monitor counts dm_we cycles and grant pulses.
// Lock scenarios build only when DM_ARB_LOCK_EN is defined.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_dm_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          a_req, a_we, b_req, b_we;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata;
  logic          a_gnt, b_gnt;
  logic [DW-1:0] a_rdata, b_rdata;
`ifdef DM_ARB_LOCK_EN
  logic          a_lock, b_lock;
`endif
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_writedata;
  logic          dm_we;
  logic [DW-1:0] dm_readdata;
  logic          busy;

  logic [DW-1:0] mem [0:15] = '{1: 32'd11, 2: 32'd22, 3: 32'd33, 8: 32'd2, default: 32'd0};

  int checks = 0;
  int errors = 0;
  int we_cycles = 0;
  int a_gnt_cnt = 0;
  int b_gnt_cnt = 0;

  int         snap;
  int         n;
  int         first_c;
  int         last_c;
  logic [3:0] order;

  always #5 clk = ~clk;

  dm_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk          (clk),
    .reset        (reset),
    .a_req        (a_req),
    .a_we         (a_we),
    .a_addr       (a_addr),
    .a_wdata      (a_wdata),
    .a_gnt        (a_gnt),
    .a_rdata      (a_rdata),
    .b_req        (b_req),
    .b_we         (b_we),
    .b_addr       (b_addr),
    .b_wdata      (b_wdata),
    .b_gnt        (b_gnt),
    .b_rdata      (b_rdata),
`ifdef DM_ARB_LOCK_EN
    .a_lock       (a_lock),
    .b_lock       (b_lock),
`endif
    .dm_addr      (dm_addr),
    .dm_writedata (dm_writedata),
    .dm_we        (dm_we),
    .dm_readdata  (dm_readdata),
    .busy         (busy)
  );

  // The DM model is write-first: during a write cycle, readdata shows the
  // data being written.
  assign dm_readdata = dm_we ? dm_writedata : mem[dm_addr[3:0]];

  always @(posedge clk) begin
    if (dm_we) mem[dm_addr[3:0]] <= dm_writedata;
  end

  always @(negedge clk) begin
    if (dm_we) we_cycles <= we_cycles + 1;
    if (a_gnt) a_gnt_cnt <= a_gnt_cnt + 1;
    if (b_gnt) b_gnt_cnt <= b_gnt_cnt + 1;
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic port, input logic req, input logic we,
                               input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    if (port == 1'b0) begin
      a_req = req; a_we = we; a_addr = addr; a_wdata = wdata;
    end else begin
      b_req = req; b_we = we; b_addr = addr; b_wdata = wdata;
    end
  endtask

  task automatic applyReset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
    applyStimulus(1'b1, 1'b0, 1'b0, '0, '0);
`ifdef DM_ARB_LOCK_EN
    a_lock = 1'b0;
    b_lock = 1'b0;
`endif
    tick();
    tick();

    $display("[TB] reset state");
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_dm_we", dm_we, 0);
    checkOutput("rst_dm_addr", dm_addr, 0);
    checkOutput("rst_dm_wdata", dm_writedata, 0);
    checkOutput("rst_a_gnt", a_gnt, 0);
    checkOutput("rst_b_gnt", b_gnt, 0);
    checkOutput("rst_a_rdata", a_rdata, 0);
    checkOutput("rst_b_rdata", b_rdata, 0);
    reset = 1'b0;
    tick();

    $display("[TB] A read of addr 8");
    snap = we_cycles;
    applyStimulus(1'b0, 1'b1, 1'b0, 32'd8, 32'd0);
    tick();
    checkOutput("t1_access_busy", busy, 1);
    checkOutput("t1_access_addr", dm_addr, 8);
    checkOutput("t1_access_no_gnt", a_gnt, 0);
    tick();
    checkOutput("t1_a_gnt", a_gnt, 1);
    checkOutput("t1_a_rdata", a_rdata, 2);
    checkOutput("t1_b_gnt", b_gnt, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd8, 32'd0);
    tick();
    checkOutput("t1_gnt_pulse_end", a_gnt, 0);
    checkOutput("t1_idle_busy", busy, 0);
    checkOutput("t1_no_write", we_cycles - snap, 0);

    $display("[TB] A write 42 to addr 8, then B read");
    snap = we_cycles;
    applyStimulus(1'b0, 1'b1, 1'b1, 32'd8, 32'd42);
    tick();
    checkOutput("t2_dm_we", dm_we, 1);
    checkOutput("t2_dm_wdata", dm_writedata, 42);
    tick();
    checkOutput("t2_a_gnt", a_gnt, 1);
    checkOutput("t2_a_rdata", a_rdata, 42);
    checkOutput("t2_we_dropped", dm_we, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd8, 32'd0);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b0, 32'd8, 32'd0);
    tick();
    tick();
    checkOutput("t2_b_gnt", b_gnt, 1);
    checkOutput("t2_b_rdata", b_rdata, 42);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd8, 32'd0);
    tick();
    checkOutput("t2_we_cycles", we_cycles - snap, 1);
    checkOutput("t2_a_rdata_held", a_rdata, 42);

    $display("[TB] simultaneous requests from reset");
    applyReset();
    applyStimulus(1'b0, 1'b1, 1'b0, 32'd1, 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'd2, 32'd0);
    order = '0; n = 0; first_c = -1; last_c = -1;
    for (int c = 0; c < 40 && n < 4; c++) begin
      tick();
      if (a_gnt || b_gnt) begin
        order = {order[2:0], b_gnt};
        if (n == 0) first_c = c;
        last_c = c;
        n++;
      end
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd1, 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd2, 32'd0);
    checkOutput("t3_grant_count", n, 4);
    checkOutput("t3_order_ABAB", order, 4'b0101);
    checkOutput("t3_first_latency", first_c, 1);
    checkOutput("t3_spacing", last_c - first_c, 9);
    checkOutput("t3_a_rdata", a_rdata, 11);
    checkOutput("t3_b_rdata", b_rdata, 22);
    tick();
    tick();

    $display("[TB] reset during B write access");
    snap = b_gnt_cnt;
    applyStimulus(1'b1, 1'b1, 1'b1, 32'd3, 32'd77);
    tick();
    checkOutput("t4_pre_dm_we", dm_we, 1);
    #1 reset = 1'b1;
    #1;
    checkOutput("t4_async_dm_we", dm_we, 0);
    checkOutput("t4_async_busy", busy, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    tick();
    tick();
    reset = 1'b0;
    tick();
    tick();
    checkOutput("t4_busy", busy, 0);
    checkOutput("t4_a_rdata", a_rdata, 0);
    checkOutput("t4_b_rdata", b_rdata, 0);
    checkOutput("t4_no_b_gnt", b_gnt_cnt - snap, 0);
    checkOutput("t4_mem_untouched", mem[3], 33);

    $display("[TB] A drops req during ACCESS");
    snap = a_gnt_cnt;
    applyStimulus(1'b0, 1'b1, 1'b0, 32'd2, 32'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd2, 32'd0);
    tick();
    checkOutput("t5_a_gnt", a_gnt, 1);
    checkOutput("t5_a_rdata", a_rdata, 22);
    tick();
    tick();
    tick();
    checkOutput("t5_single_gnt", a_gnt_cnt - snap, 1);
    checkOutput("t5_idle", busy, 0);

`ifdef DM_ARB_LOCK_EN
    $display("[TB] A lock sequence with B waiting");
    applyReset();
    a_lock = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b0, 32'd2, 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'd1, 32'd0);
    order = '0; n = 0;
    for (int c = 0; c < 60 && n < 4; c++) begin
      tick();
      if (a_gnt || b_gnt) begin
        order = {order[2:0], b_gnt};
        n++;
        if (n == 3) a_lock = 1'b0;
      end
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd2, 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd1, 32'd0);
    checkOutput("t6_grant_count", n, 4);
    checkOutput("t6_order_AAAB", order, 4'b0001);
    checkOutput("t6_b_rdata", b_rdata, 11);
    tick();
    tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
